// File: rtl/lh3_pkg.sv
// Shared types and constants for the 3-tap horizontal smoothing filter.
package lh3_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int          DATA_W_DEF = 16;
  localparam int          KERN_RND   = 2;
  localparam int          KERN_SHIFT = 2;
  localparam logic [15:0] OUT_COUNT  = 16'h1;

endpackage

// File: rtl/lh3_tap3_kernel.sv
// Combinational [1 2 1]/4 kernel with round-half-up.
module lh3_tap3_kernel
  import lh3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int SUM_W = DATA_W + 2;

  // Worst case 4*max+2 still fits in SUM_W, so no saturation is needed.
  logic [SUM_W-1:0] sum;

  assign sum = {2'b00, a_i} + {1'b0, b_i, 1'b0} + {2'b00, c_i} + SUM_W'(KERN_RND);
  assign y_o = sum[DATA_W+KERN_SHIFT-1:KERN_SHIFT];

endmodule

// File: rtl/lh3_hsmooth.sv
// Streaming horizontal smoother: per-row [1 2 1]/4 with edge replication,
// zero-latency token handshake and one flush cycle at the end of each row.
module lh3_hsmooth
  import lh3_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic              In1_SEND,
  input  logic [15:0]       In1_COUNT,
  output logic              In1_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic              Out1_SEND,
  input  logic              Out1_RDY,
  input  logic              Out1_ACK,
  output logic [15:0]       Out1_COUNT
);

  localparam int               COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              ack_c, send_c;
  logic [DATA_W-1:0] tap_c;
  logic              unused_inputs;

  assign unused_inputs = ^{In1_COUNT, Out1_ACK};

  // Right-edge replication: in FLUSH the missing x[W] is taken as x[W-1].
  assign tap_c = (state_q == FLUSH) ? cur_q : In1_DATA;

  lh3_tap3_kernel #(
    .DATA_W(DATA_W)
  ) u_kernel (
    .a_i(prev_q),
    .b_i(cur_q),
    .c_i(tap_c),
    .y_o(Out1_DATA)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= FIRST;
      prev_q  <= '0;
      cur_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    col_d   = col_q;
    ack_c   = 1'b0;
    send_c  = 1'b0;
    case (state_q)
      FIRST: begin
        // Left-edge replication: x[-1] is seeded with x[0].
        if (In1_SEND) begin
          ack_c   = 1'b1;
          prev_d  = In1_DATA;
          cur_d   = In1_DATA;
          col_d   = COL_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (In1_SEND && Out1_RDY) begin
          ack_c  = 1'b1;
          send_c = 1'b1;
          prev_d = cur_q;
          cur_d  = In1_DATA;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = FLUSH;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      FLUSH: begin
        if (Out1_RDY) begin
          send_c  = 1'b1;
          state_d = FIRST;
        end
      end
      default: state_d = FIRST;
    endcase
  end

  // Handshake outputs are combinational; hold them low while reset is applied.
  assign In1_ACK    = ack_c & ~RESET;
  assign Out1_SEND  = send_c & ~RESET;
  assign Out1_COUNT = OUT_COUNT;

endmodule

// File: tb/tb_lh3_hsmooth.sv
// Directed bench for lh3_hsmooth at IMG_WIDTH=4, DATA_W=16.
module tb_lh3_hsmooth;

  logic        CLK;
  logic        RESET;
  logic [15:0] In1_DATA;
  logic        In1_SEND;
  logic [15:0] In1_COUNT;
  logic        In1_ACK;
  logic [15:0] Out1_DATA;
  logic        Out1_SEND;
  logic        Out1_RDY;
  logic        Out1_ACK;
  logic [15:0] Out1_COUNT;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int timeouts  = 0;
  int proto_err = 0;
  logic [15:0] out_q[$];

  lh3_hsmooth #(
    .IMG_WIDTH(4),
    .DATA_W(16)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .In1_DATA(In1_DATA),
    .In1_SEND(In1_SEND),
    .In1_COUNT(In1_COUNT),
    .In1_ACK(In1_ACK),
    .Out1_DATA(Out1_DATA),
    .Out1_SEND(Out1_SEND),
    .Out1_RDY(Out1_RDY),
    .Out1_ACK(Out1_ACK),
    .Out1_COUNT(Out1_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output collector and handshake-rule monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (Out1_SEND) out_q.push_back(Out1_DATA);
      if (Out1_SEND && !Out1_RDY) proto_err++;
      if (In1_ACK && !In1_SEND) proto_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    RESET    = 1'b1;
    In1_SEND = 1'b0;
    In1_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    out_q.delete();
  endtask

  task automatic send_tokens(input logic [15:0] v[8], input int n);
    for (int i = 0; i < n; i++) begin
      bit got = 0;
      In1_DATA = v[i];
      In1_SEND = 1'b1;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge CLK);
        if (In1_ACK) got = 1;
      end
      if (!got) timeouts++;
      @(posedge CLK);
      #1;
    end
    In1_SEND = 1'b0;
    In1_DATA = '0;
  endtask

  task automatic wait_outputs(input int n);
    for (int t = 0; t < 50 && out_q.size() < n; t++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    In1_SEND = 1'b1;
    In1_DATA = 16'd9;
    Out1_RDY = 1'b1;
    @(negedge CLK);
    check_cnt++;
    if (In1_ACK !== 1'b0) $display("FAIL reset_ack: got %b want 0", In1_ACK);
    else pass_cnt++;
    check_cnt++;
    if (Out1_SEND !== 1'b0) $display("FAIL reset_send: got %b want 0", Out1_SEND);
    else pass_cnt++;
    check_cnt++;
    if (Out1_COUNT !== 16'h1) $display("FAIL reset_count: got %h want 0001", Out1_COUNT);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_cnt++;
    if (In1_ACK !== 1'b1) $display("FAIL first_cycle_ack: got %b want 1", In1_ACK);
    else pass_cnt++;
    check_cnt++;
    if (Out1_SEND !== 1'b0) $display("FAIL first_no_output: got %b want 0", Out1_SEND);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    In1_SEND = 1'b0;
    do_reset();
  endtask

  task automatic check_row(input string name, input logic [15:0] e[8], input int n);
    check_cnt++;
    if (out_q.size() != n) $display("FAIL %s_count: got %0d outputs want %0d", name, out_q.size(), n);
    else pass_cnt++;
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      check_cnt++;
      if (out_q[i] !== e[i]) $display("FAIL %s[%0d]: got %0d want %0d", name, i, out_q[i], e[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    logic [15:0] v[8] = '{16'd4, 16'd8, 16'd12, 16'd16, 0, 0, 0, 0};
    logic [15:0] e[8] = '{16'd5, 16'd8, 16'd12, 16'd15, 0, 0, 0, 0};
    bit          flush_seen = 0;
    do_reset();
    Out1_RDY = 1'b1;
    send_tokens(v, 3);
    In1_DATA = 16'd16;
    In1_SEND = 1'b1;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    // FLUSH cycle: output valid while the pending input is refused.
    @(negedge CLK);
    flush_seen = (Out1_SEND === 1'b1) && (In1_ACK === 1'b0);
    check_cnt++;
    if (!flush_seen) $display("FAIL flush_cycle: send=%b ack=%b want send=1 ack=0", Out1_SEND, In1_ACK);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    In1_SEND = 1'b0;
    wait_outputs(4);
    check_row("basic", e, 4);
  endtask

  task automatic test_max();
    logic [15:0] v[8] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0};
    do_reset();
    Out1_RDY = 1'b1;
    send_tokens(v, 4);
    wait_outputs(4);
    check_row("max", v, 4);
  endtask

  task automatic test_backpressure();
    logic [15:0] v0[8] = '{16'd4, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] v1[8] = '{16'd8, 16'd12, 16'd16, 0, 0, 0, 0, 0};
    logic [15:0] e[8]  = '{16'd5, 16'd8, 16'd12, 16'd15, 0, 0, 0, 0};
    do_reset();
    Out1_RDY = 1'b1;
    send_tokens(v0, 1);
    In1_DATA = 16'd8;
    In1_SEND = 1'b1;
    Out1_RDY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check_cnt++;
      if (In1_ACK !== 1'b0 || Out1_SEND !== 1'b0)
        $display("FAIL bp_stall[%0d]: ack=%b send=%b want 0 0", c, In1_ACK, Out1_SEND);
      else pass_cnt++;
      @(posedge CLK);
      #1;
    end
    Out1_RDY = 1'b1;
    send_tokens(v1, 3);
    wait_outputs(4);
    check_row("bp", e, 4);
  endtask

  task automatic test_back_to_back();
    logic [15:0] v[8] = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd16, 16'd12, 16'd8, 16'd4};
    logic [15:0] e[8] = '{16'd5, 16'd8, 16'd12, 16'd15, 16'd15, 16'd12, 16'd8, 16'd5};
    do_reset();
    Out1_RDY = 1'b1;
    send_tokens(v, 8);
    wait_outputs(8);
    check_row("b2b", e, 8);
  endtask

  task automatic test_mid_reset();
    logic [15:0] v0[8] = '{16'd100, 16'd200, 0, 0, 0, 0, 0, 0};
    logic [15:0] v[8]  = '{16'd4, 16'd8, 16'd12, 16'd16, 0, 0, 0, 0};
    logic [15:0] e[8]  = '{16'd5, 16'd8, 16'd12, 16'd15, 0, 0, 0, 0};
    do_reset();
    Out1_RDY = 1'b1;
    send_tokens(v0, 2);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    out_q.delete();
    send_tokens(v, 4);
    wait_outputs(4);
    check_row("midrst", e, 4);
  endtask

  task automatic test_continuous();
    int ack_bad = 0;
    int cnt_bad = 0;
    do_reset();
    Out1_RDY = 1'b1;
    In1_DATA = 16'd7;
    In1_SEND = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (In1_ACK !== ((i % 5) != 4)) begin
        ack_bad++;
        $display("FAIL cont_ack[%0d]: got %b want %b", i, In1_ACK, ((i % 5) != 4));
      end
      if (Out1_COUNT !== 16'h1) cnt_bad++;
      @(posedge CLK);
      #1;
    end
    In1_SEND = 1'b0;
    check_cnt++;
    if (ack_bad != 0) $display("FAIL cont_ack_pattern: got %0d bad cycles want 0", ack_bad);
    else pass_cnt++;
    check_cnt++;
    if (cnt_bad != 0) $display("FAIL cont_out_count: got %0d bad cycles want 0", cnt_bad);
    else pass_cnt++;
    check_cnt++;
    if (out_q.size() != 12) $display("FAIL cont_outputs: got %0d want 12", out_q.size());
    else pass_cnt++;
    for (int i = 0; i < out_q.size(); i++) begin
      check_cnt++;
      if (out_q[i] !== 16'd7) $display("FAIL cont_data[%0d]: got %0d want 7", i, out_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    RESET     = 1'b1;
    In1_DATA  = '0;
    In1_SEND  = 1'b0;
    In1_COUNT = 16'd4;
    Out1_RDY  = 1'b1;
    Out1_ACK  = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_continuous();
    check_cnt++;
    if (timeouts != 0) $display("FAIL handshake_timeout: got %0d timeouts want 0", timeouts);
    else pass_cnt++;
    check_cnt++;
    if (proto_err != 0) $display("FAIL protocol_rules: got %0d violations want 0", proto_err);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
